alu_share_scheduler: RTL and testbench
======================================

// Module: alu_share_scheduler
// PURPOSE
// - Shares one 24-bit ALU element (ops MOV/SIN/COS/ADD/MULT/DIV) among NREQ requesters.
// - Round-robin arbitration and a ready/valid handshake per requester.
// - Drives the ALU operands and select, then holds them for the op's multicycle budget.
// - Returns the captured result, tagged with the requester id, on one shared response channel.
// PARAMETERS
// - N        24  data width (ALU operand/result)
// - NREQ     4   number of requesters (2..8)
// - MUL_CYC  2   cycles operands are held for MULT before capture (>=1)
// - DIV_CYC  6   cycles operands are held for DIV before capture (>=1)
// - LUT_LAT  2   cycles operands are held for SIN/COS (sin/cos table read latency, >=1)
// PORTS
// - clk         in   1          clock, rising edge
// - rst         in   1          synchronous, active-high reset
// - req_valid   in   NREQ       request valid, one bit per requester
// - req_op      in   4*NREQ     op select per requester; slot i = [4i+3:4i]
// - req_a       in   N*NREQ     operand a per requester; slot i = [N*i+N-1:N*i]
// - req_b       in   N*NREQ     operand b per requester, same packing
// - req_ready   out  NREQ       one-hot grant/accept pulse
// - alu_a       out  N          to ALU a; also used as sin/cos table address
// - alu_b       out  N          to ALU b
// - alu_select  out  4          to ALU select
// - alu_out     in   N          ALU result
// - rsp_valid   out  1          response valid
// - rsp_ready   in   1          response accept
// - rsp_id      out  $clog2(NREQ)  requester index of the response
// - rsp_data    out  N          captured result
// - rsp_err     out  1          illegal op or divide-by-zero
// - busy        out  1          high in any state other than IDLE
// - perf_ops    out  32         completed-op counter (see CONFIGURATION)
// - perf_busy   out  32         busy-cycle counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset values:
//   - state=IDLE; rr_ptr=0.
//   - All outputs 0, including req_ready, alu_select, rsp_* and perf_*.
// - Op cycles C:
//   - MOV (1010), ADD (1101): C=1.
//   - MULT (1110): C=MUL_CYC.
//   - DIV (1111): C=DIV_CYC.
//   - SIN (1011), COS (1100): C=LUT_LAT.
// - IDLE:
//   - Search requesters rr_ptr, rr_ptr+1, ... (mod NREQ) for the first with req_valid high.
//   - Winner g: req_ready[g]=1 for exactly this cycle (combinational); latch op/a/b/g.
//   - Set rr_ptr <= g+1 (wraps NREQ-1 -> 0); go to EXEC.
//   - No valid request: remain in IDLE, req_ready=0.
// - EXEC:
//   - alu_a/alu_b/alu_select are driven from the latched registers, stable for C cycles.
//   - Down-counter is loaded with C-1; at count 0, capture alu_out into rsp_data; go to RESP.
// - RESP:
//   - rsp_valid=1; rsp_id/rsp_data/rsp_err held stable until rsp_ready.
//   - rsp_valid & rsp_ready: go to IDLE. No grant is issued in that same cycle.
// - ALU outputs are 0 in IDLE and RESP (alu_select=0000), preventing spurious table reads.
// - Latency: accept at cycle T -> rsp_valid first high at T+1+C (MOV/ADD: T+2).
// - Throughput: at most one op in flight; next grant no earlier than the cycle after response accept.
// - Illegal op (0000..1001):
//   - Skips EXEC; RESP next cycle with rsp_data=0, rsp_err=1.
// - DIV with b==0:
//   - Skips EXEC; RESP next cycle with rsp_data={N{1'b1}}, rsp_err=1.
// - rsp_err=0 for all other ops.
// - Arithmetic:
//   - rsp_data is alu_out verbatim (N bits, unsigned).
//   - No saturation; MULT/ADD truncation is the ALU's.
// - Simultaneous requests: round-robin only; no requester is granted twice while another waits.
// - Requester drops req_valid before grant: no effect, no grant.
// - Requester drops req_valid after grant: op still completes.
// - rst during EXEC or RESP:
//   - Next cycle state=IDLE, rr_ptr=0, outputs at reset values.
//   - The in-flight op is discarded; no response is issued.
// - busy = (state != IDLE).
// CONFIGURATION
// - ALU_SCHED_PERF_EN defined:
//   - perf_ops increments on each rsp_valid & rsp_ready.
//   - perf_busy increments each cycle busy=1.
//   - Both are 32-bit wrapping counters (0xFFFFFFFF -> 0), cleared by rst.
// - ALU_SCHED_PERF_EN undefined: perf_ops and perf_busy are tied to 0; no counter flops.
// TESTING
// - Req0 ADD a=5 b=7, rsp_ready=1 -> req_ready[0] at T; rsp_valid at T+2, rsp_data=12, rsp_id=0, rsp_err=0.
// - Reqs 0..3 all valid each cycle, MOV b=id, rr_ptr=0 -> grants in order 0,1,2,3,0; rsp_data=id each.
// - Req2 DIV a=100 b=7 (DIV_CYC=6) -> alu_select=1111 stable 6 cycles; rsp_data=14 at T+7.
// - Req1 DIV b=0 -> rsp at T+1, rsp_data=0xFFFFFF, rsp_err=1.
// - Req1 op=0011 -> rsp at T+1, rsp_data=0, rsp_err=1.
// - MULT 3*4 with rsp_ready held low 5 cycles -> rsp_valid/rsp_data=12 held stable; no new grant until accept.
// - rst pulsed mid-EXEC -> IDLE next cycle, no response emitted.
// - With ALU_SCHED_PERF_EN: after 3 ops, perf_ops=3.
// - Without ALU_SCHED_PERF_EN: perf_ops and perf_busy stay 0.

Source files
------------

// File: rtl/alu_share_scheduler.sv
// Round-robin scheduler sharing one multicycle ALU among NREQ requesters.
// Define ALU_SCHED_PERF_EN to build the perf_ops/perf_busy counters; otherwise they read 0.
module alu_share_scheduler #(
  parameter int N       = 24,
  parameter int NREQ    = 4,
  parameter int MUL_CYC = 2,
  parameter int DIV_CYC = 6,
  parameter int LUT_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [4*NREQ-1:0]         req_op,
  input  logic [N*NREQ-1:0]         req_a,
  input  logic [N*NREQ-1:0]         req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [N-1:0]              alu_a,
  output logic [N-1:0]              alu_b,
  output logic [3:0]                alu_select,
  input  logic [N-1:0]              alu_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [N-1:0]              rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [31:0]               perf_ops,
  output logic [31:0]               perf_busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = 16;

  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_SIN  = 4'b1011;
  localparam logic [3:0] OP_COS  = 4'b1100;
  localparam logic [3:0] OP_ADD  = 4'b1101;
  localparam logic [3:0] OP_MULT = 4'b1110;
  localparam logic [3:0] OP_DIV  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  id_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    alu_a_q;
  logic [N-1:0]    alu_b_q;
  logic [3:0]      alu_sel_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [N-1:0]    rsp_data_q;
  logic            rsp_err_q;

  logic            found;
  logic [IDW-1:0]  gnt_id;
  logic [3:0]      gnt_op;
  logic [N-1:0]    gnt_a;
  logic [N-1:0]    gnt_b;
  logic            grant_ok;
  logic            gnt_illegal;
  logic            gnt_div0;
  logic [IDW-1:0]  ptr_nxt;

  // Hold budget minus one, i.e. the down-counter load value.
  function automatic logic [CW-1:0] op_budget(input logic [3:0] op);
    logic [CW-1:0] c;
    c = '0;
    case (op)
      OP_MULT:        c = CW'(MUL_CYC - 1);
      OP_DIV:         c = CW'(DIV_CYC - 1);
      OP_SIN, OP_COS: c = CW'(LUT_LAT - 1);
      default:        c = '0;
    endcase
    return c;
  endfunction

  // First valid requester at or after rr_ptr, scanning modulo NREQ.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    gnt_op = '0;
    gnt_a  = '0;
    gnt_b  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
        gnt_op = req_op[4*idx +: 4];
        gnt_a  = req_a[N*idx +: N];
        gnt_b  = req_b[N*idx +: N];
      end
    end
  end

  assign grant_ok    = (state_q == S_IDLE) && found && !rst;
  assign req_ready   = grant_ok ? (NREQ'(1) << gnt_id) : '0;
  assign gnt_illegal = (gnt_op < OP_MOV);
  assign gnt_div0    = (gnt_op == OP_DIV) && (gnt_b == '0);
  assign ptr_nxt     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  // The ALU drive registers double as the latched operands: they are only
  // needed while in EXEC and must read zero everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            rr_ptr_q <= ptr_nxt;
            id_q     <= gnt_id;
            if (gnt_illegal || gnt_div0) begin
              rsp_valid_q <= 1'b1;
              rsp_id_q    <= gnt_id;
              rsp_data_q  <= gnt_div0 ? '1 : '0;
              rsp_err_q   <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              alu_a_q   <= gnt_a;
              alu_b_q   <= gnt_b;
              alu_sel_q <= gnt_op;
              cnt_q     <= op_budget(gnt_op);
              state_q   <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_data_q  <= alu_out;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE);

`ifdef ALU_SCHED_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) perf_ops_q <= perf_ops_q + 32'd1;
      if (busy) perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_busy = perf_busy_q;
`else
  assign perf_ops  = '0;
  assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Scoreboard bench for alu_share_scheduler with a behavioural ALU that only
// returns a correct result once its operands have been held long enough.
module tb_alu_share_scheduler;

  localparam int N       = 24;
  localparam int NREQ    = 4;
  localparam int IDW     = $clog2(NREQ);
  localparam int MUL_CYC = 2;
  localparam int DIV_CYC = 6;
  localparam int LUT_LAT = 2;

  localparam logic [3:0] MOV  = 4'b1010;
  localparam logic [3:0] SIN  = 4'b1011;
  localparam logic [3:0] COS  = 4'b1100;
  localparam logic [3:0] ADD  = 4'b1101;
  localparam logic [3:0] MULT = 4'b1110;
  localparam logic [3:0] DIV  = 4'b1111;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [4*NREQ-1:0]   req_op;
  logic [N*NREQ-1:0]   req_a;
  logic [N*NREQ-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic [N-1:0]        alu_a;
  logic [N-1:0]        alu_b;
  logic [3:0]          alu_select;
  logic [N-1:0]        alu_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [N-1:0]        rsp_data;
  logic                rsp_err;
  logic                busy;
  logic [31:0]         perf_ops;
  logic [31:0]         perf_busy;

  alu_share_scheduler #(
    .N(N), .NREQ(NREQ), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC), .LUT_LAT(LUT_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .perf_ops(perf_ops), .perf_busy(perf_busy)
  );

  typedef struct { int id; logic [3:0] op; logic [N-1:0] a; logic [N-1:0] b; } req_t;
  typedef struct { int id; logic [N-1:0] data; logic err; int lat; } exp_t;

  req_t pend[$];
  exp_t expq[$];
  int   gntq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int ops_since_rst = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int need(input logic [3:0] op);
    case (op)
      MOV, ADD: return 1;
      MULT:     return MUL_CYC;
      DIV:      return DIV_CYC;
      SIN, COS: return LUT_LAT;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [N-1:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      MOV:     r = b;
      SIN:     r = a ^ 24'h5A5A5A;
      COS:     r = a ^ 24'hA5A5A5;
      ADD:     r = a + b;
      MULT:    r = a * b;
      DIV:     r = (b != '0) ? a / b : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic issue(input int id, input logic [3:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] data, input logic err,
                       input bit expect_rsp);
    req_t r;
    exp_t e;
    r.id = id; r.op = op; r.a = a; r.b = b;
    pend.push_back(r);
    gntq.push_back(id);
    if (expect_rsp) begin
      e.id = id; e.data = data; e.err = err;
      e.lat = err ? 1 : 1 + need(op);
      expq.push_back(e);
    end
  endtask

  task automatic wait_done(input int max);
    int k;
    k = 0;
    while ((expq.size() != 0 || pend.size() != 0 || busy) && k < max) begin
      @(negedge clk);
      k++;
    end
    check("wait_done_bound", 64'(k < max), 64'(1));
  endtask

  // Requesters: present the oldest pending op per id, retire it once granted.
  initial begin
    logic [NREQ-1:0] g;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    forever begin
      @(negedge clk);
      g = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          for (int j = 0; j < pend.size(); j++) begin
            if (pend[j].id == i) begin
              pend.delete(j);
              break;
            end
          end
        end
      end
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
        for (int j = 0; j < pend.size(); j++) begin
          if (pend[j].id == i) begin
            req_valid[i]     = 1'b1;
            req_op[4*i +: 4] = pend[j].op;
            req_a[N*i +: N]  = pend[j].a;
            req_b[N*i +: N]  = pend[j].b;
            break;
          end
        end
      end
    end
  end

  // ALU model plus monitor.
  initial begin
    int cyc, held, grant_cyc, lat, g;
    bit first_seen, run_rst, prev_ready;
    logic [3:0] m_sel;
    logic [N-1:0] m_a, m_b;
    logic [IDW+N:0] prev_rsp;
    exp_t e;
    cyc = 0; held = 0; grant_cyc = 0; lat = 0; first_seen = 1'b1; run_rst = 1'b0;
    prev_ready = 1'b1; m_sel = '0; m_a = '0; m_b = '0; prev_rsp = '0;
    alu_out = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) run_rst = 1'b1;
      if (alu_select != '0 && alu_select == m_sel && alu_a == m_a && alu_b == m_b) begin
        held++;
      end else begin
        if (m_sel != '0 && !run_rst) check("alu_hold_cycles", 64'(held), 64'(need(m_sel)));
        held = (alu_select != '0) ? 1 : 0;
        run_rst = rst;
      end
      m_sel = alu_select; m_a = alu_a; m_b = alu_b;
      alu_out = (alu_select != '0 && held >= need(alu_select)) ?
                alu_fn(alu_select, alu_a, alu_b) : 24'hBADBAD;

      if (req_ready != '0) begin
        check("grant_while_busy", 64'(busy), 64'(0));
        if (gntq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL grant_unexpected: req_ready=0x%0h with no grant expected", req_ready);
        end else begin
          g = gntq.pop_front();
          check("grant_id", 64'(req_ready), 64'(1) << g);
        end
        grant_cyc = cyc;
        first_seen = 1'b0;
      end

      if (rsp_valid) begin
        check("alu_zero_in_resp", 64'({alu_select, alu_a, alu_b}), 64'(0));
        if (!first_seen) begin
          lat = cyc - grant_cyc;
          first_seen = 1'b1;
        end else if (!prev_ready) begin
          check("rsp_hold_stable", 64'({rsp_id, rsp_data, rsp_err}), 64'(prev_rsp));
        end
        prev_rsp = {rsp_id, rsp_data, rsp_err};
        prev_ready = rsp_ready;
        if (rsp_ready) begin
          n_rsp++;
          ops_since_rst++;
          if (expq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_unexpected: id=%0d data=0x%0h err=%0b", rsp_id, rsp_data, rsp_err);
          end else begin
            e = expq.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_data", 64'(rsp_data), 64'(e.data));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("rsp_latency", 64'(lat), 64'(e.lat));
          end
        end
      end
      if (rst) ops_since_rst = 0;
    end
  end

  initial begin
    int k;
    int rsp_before;
    rst = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_alu", 64'({alu_a, alu_b, alu_select}), 64'(0));
    check("reset_rsp", 64'({rsp_valid, rsp_id, rsp_data, rsp_err}), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_perf", {perf_ops, perf_busy}, 64'(0));

    issue(0, ADD, 24'd5, 24'd7, 24'd12, 1'b0, 1'b1);           wait_done(50);
    issue(2, DIV, 24'd100, 24'd7, 24'd14, 1'b0, 1'b1);         wait_done(50);
    issue(1, DIV, 24'd9, 24'd0, 24'hFFFFFF, 1'b1, 1'b1);       wait_done(50);
    issue(1, 4'b0011, 24'd1, 24'd2, 24'd0, 1'b1, 1'b1);        wait_done(50);
    issue(0, 4'b0000, 24'd3, 24'd3, 24'd0, 1'b1, 1'b1);        wait_done(50);
    issue(3, 4'b1001, 24'd3, 24'd3, 24'd0, 1'b1, 1'b1);        wait_done(50);
    issue(1, SIN, 24'd3, 24'd0, 24'h5A5A59, 1'b0, 1'b1);       wait_done(50);
    issue(1, COS, 24'd3, 24'd0, 24'hA5A5A6, 1'b0, 1'b1);       wait_done(50);
    issue(2, ADD, 24'hFFFFFF, 24'd1, 24'd0, 1'b0, 1'b1);       wait_done(50);
    issue(3, MULT, 24'h100000, 24'h10, 24'd0, 1'b0, 1'b1);     wait_done(50);

    // Response backpressure: a waiting requester must not be granted early.
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(3, MULT, 24'd3, 24'd4, 24'd12, 1'b0, 1'b1);
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    check("stall_rsp_bound", 64'(k < 50), 64'(1));
    issue(0, MOV, 24'd0, 24'd9, 24'd9, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_done(50);

    // Reset while DIV is executing: op discarded, pointer cleared.
    issue(2, DIV, 24'd50, 24'd5, 24'd10, 1'b0, 1'b0);
    k = 0;
    while (alu_select != DIV && k < 50) begin @(negedge clk); k++; end
    check("abort_exec_bound", 64'(k < 50), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_outputs", 64'({rsp_valid, alu_select, rsp_err}), 64'(0));
    rsp_before = n_rsp;
    repeat (10) @(negedge clk);
    check("abort_no_rsp", 64'(n_rsp), 64'(rsp_before));

    // All four requesters pending at once, starting from rr_ptr=0.
    issue(0, MOV, 24'd0, 24'd0, 24'd0, 1'b0, 1'b1);
    issue(1, MOV, 24'd0, 24'd1, 24'd1, 1'b0, 1'b1);
    issue(2, MOV, 24'd0, 24'd2, 24'd2, 1'b0, 1'b1);
    issue(3, MOV, 24'd0, 24'd3, 24'd3, 1'b0, 1'b1);
    issue(0, MOV, 24'd0, 24'd0, 24'd0, 1'b0, 1'b1);
    wait_done(100);

    repeat (2) @(negedge clk);
    check("grants_outstanding", 64'(gntq.size()), 64'(0));
`ifdef ALU_SCHED_PERF_EN
    check("perf_ops", 64'(perf_ops), 64'(ops_since_rst));
`else
    check("perf_ops_off", 64'(perf_ops), 64'(0));
    check("perf_busy_off", 64'(perf_busy), 64'(0));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
